stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DW, default 4, data width in bits.
REQ-002 Parameter DEPTH, default 16, number of stack entries.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_a, req_b  in  1  per-requester transaction request, level.
REQ-006 rw_a, rw_b  in  1  per-requester operation: 1 = push, 0 = pop.
REQ-007 datain_a, datain_b  in  DW  per-requester push data.
REQ-008 gnt_a, gnt_b  out  1  one-cycle pulse: request accepted.
REQ-009 done_a, done_b  out  1  one-cycle pulse: transaction complete.
REQ-010 dataout  out  DW  pop result, valid while a done pulse is high.
REQ-011 err  out  1  high with done: push-on-full or pop-on-empty rejected.
REQ-012 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 full, empty  out  1  count == DEPTH, count == 0.

Function
REQ-014 FSM states IDLE, EXEC, RESP; IDLE->EXEC on any sampled req; EXEC->RESP always; RESP->IDLE always.
REQ-015 req_x, rw_x and datain_x are sampled only in IDLE; winner's rw and data are latched on the IDLE->EXEC edge.
REQ-016 Arbitration is round-robin: one requester active -> that requester wins; both active -> the requester holding priority wins.
REQ-017 Priority passes to the non-winner on each RESP->IDLE transition; the priority holder does not change while IDLE.
REQ-018 gnt_x is registered and high for exactly the EXEC cycle of a transaction won by x.
REQ-019 Push in EXEC with count < DEPTH: mem[count] <= data, count increments.
REQ-020 Pop in EXEC with count > 0: dataout <= mem[count-1], count decrements.
REQ-021 Push with count == DEPTH: memory and count unchanged, err high in RESP.
REQ-022 Pop with count == 0: count unchanged, dataout = 0, err high in RESP.
REQ-023 done_x is high for exactly the RESP cycle; err and dataout are valid in that same cycle.
REQ-024 err is low outside RESP; dataout holds its last value outside RESP.
REQ-025 Transaction latency is fixed: req sampled at IDLE edge N, gnt in cycle N+1, done in cycle N+2, next sample at N+3.
REQ-026 A requester deasserts req the cycle after its done pulse; req still high in IDLE starts a new transaction.
REQ-027 The loser's req is not queued separately; it stays pending and is re-sampled at the next IDLE.
REQ-028 full, empty and count are derived combinationally from the registered pointer; count never exceeds DEPTH and never wraps.

Reset
REQ-029 Asserting rst (low) forces state IDLE, count 0, priority to requester A, all gnt/done/err low, dataout 0, empty high, full low.
REQ-030 Reset during EXEC or RESP abandons the transaction: no done pulse follows, and the pointer returns to 0.
REQ-031 Memory contents are not reset; they are unobservable until rewritten, because count is 0.
REQ-032 Release of rst is synchronised internally: a 2-flop synchroniser drives deassertion, and the FSM leaves IDLE no earlier than the second clk edge after release.

Structure
REQ-033 Shared package stack_pkg holds DW, DEPTH, the state enumeration (IDLE, EXEC, RESP) and the constants OP_PUSH = 1, OP_POP = 0.
REQ-034 Storage is a sub-module stack_mem: DEPTH x DW register file, one synchronous write port, one read port, no reset.
REQ-035 Arbitration, FSM, pointer and flags reside in stack_arbiter; stack_mem is instantiated once.

Verification
REQ-036 Scenario: reset, then A pushes 4'h3, 4'h7, 4'h9 in turn -> gnt_a each at N+1, done_a at N+2, count 3, err 0.
REQ-037 Scenario: from that state, B pops three times -> dataout 9, 7, 3 with done_b; then a fourth pop -> err 1, dataout 0, count 0, empty 1.
REQ-038 Scenario: req_a and req_b both high continuously after reset -> grants alternate A, B, A, B; no requester is granted twice in a row.
REQ-039 Scenario: 16 pushes 4'h0..4'hF, then a 17th push of 4'h5 -> full 1, err 1, count 16; the next pop returns 4'hF.
REQ-040 Scenario: rst asserted low during an EXEC cycle -> no done pulse; count 0, priority A, all outputs at reset values immediately (asynchronous).
REQ-041 Scenario: a requester holds req one cycle past its done -> a second transaction is started and gnt is observed at the expected cycle.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the arbitrated stack: default geometry, FSM states,
// operation encoding and the round-robin pick rule.
package stack_pkg;

    localparam int DW    = 4;
    localparam int DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // B wins when it is the only requester or when it holds priority
    function automatic logic arb_pick_b(input logic a, input logic b, input logic prio_b);
        return b & (~a | prio_b);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x DW register file backing the stack: one synchronous write port,
// one combinational read port, contents intentionally not reset.
module stack_mem #(
    parameter int DW    = stack_pkg::DW,
    parameter int DEPTH = stack_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DW-1:0]              i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DW-1:0]              o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a LIFO stack. IDLE samples requests,
// EXEC performs the push or pop, RESP reports completion with err/dataout.
module stack_arbiter #(
    parameter int DW    = stack_pkg::DW,
    parameter int DEPTH = stack_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_a,
    input  logic                     req_b,
    input  logic                     rw_a,
    input  logic                     rw_b,
    input  logic [DW-1:0]            datain_a,
    input  logic [DW-1:0]            datain_b,
    output logic                     gnt_a,
    output logic                     gnt_b,
    output logic                     done_a,
    output logic                     done_b,
    output logic [DW-1:0]            dataout,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import stack_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] PTR_MAX = CW'(DEPTH);

    logic [1:0]    r_sync;
    logic          w_rst_n;
    state_e        r_state;
    logic [CW-1:0] r_ptr;
    logic          r_prio_b;
    logic          r_win_b;
    logic          r_op;
    logic [DW-1:0] r_data;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_done_a;
    logic          r_done_b;
    logic [DW-1:0] r_dataout;
    logic          r_err;

    logic          w_pick_b;
    logic          w_full;
    logic          w_empty;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_rdata;

    // Reset synchroniser: assertion is immediate, release waits two clk edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_rst_n  = r_sync[1];
    assign w_pick_b = arb_pick_b(req_a, req_b, r_prio_b);
    assign w_full   = (r_ptr == PTR_MAX);
    assign w_empty  = (r_ptr == {CW{1'b0}});
    assign w_we     = (r_state == EXEC) && (r_op == OP_PUSH) && !w_full;
    assign w_waddr  = AW'(r_ptr);
    assign w_raddr  = AW'(r_ptr - CW'(1));

    stack_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (r_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Transaction FSM with arbitration, pointer update and registered strobes
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= {CW{1'b0}};
            r_prio_b  <= 1'b0;
            r_win_b   <= 1'b0;
            r_op      <= OP_POP;
            r_data    <= {DW{1'b0}};
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_done_a  <= 1'b0;
            r_done_b  <= 1'b0;
            r_dataout <= {DW{1'b0}};
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_a || req_b) begin
                        r_state <= EXEC;
                        r_win_b <= w_pick_b;
                        r_op    <= w_pick_b ? rw_b : rw_a;
                        r_data  <= w_pick_b ? datain_b : datain_a;
                        r_gnt_a <= !w_pick_b;
                        r_gnt_b <= w_pick_b;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EXEC: begin
                    r_state  <= RESP;
                    r_gnt_a  <= 1'b0;
                    r_gnt_b  <= 1'b0;
                    r_done_a <= !r_win_b;
                    r_done_b <= r_win_b;
                    if (r_op == OP_PUSH) begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + CW'(1);
                            r_err <= 1'b0;
                        end
                    end else begin
                        // An empty pop reports zero rather than stale data
                        if (w_empty) begin
                            r_err     <= 1'b1;
                            r_dataout <= {DW{1'b0}};
                        end else begin
                            r_ptr     <= r_ptr - CW'(1);
                            r_dataout <= w_rdata;
                            r_err     <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_done_a <= 1'b0;
                    r_done_b <= 1'b0;
                    r_err    <= 1'b0;
                    r_prio_b <= !r_win_b;
                end
                default: begin
                    r_state  <= IDLE;
                    r_gnt_a  <= 1'b0;
                    r_gnt_b  <= 1'b0;
                    r_done_a <= 1'b0;
                    r_done_b <= 1'b0;
                    r_err    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_a   = r_gnt_a;
    assign gnt_b   = r_gnt_b;
    assign done_a  = r_done_a;
    assign done_b  = r_done_b;
    assign dataout = r_dataout;
    assign err     = r_err;
    assign count   = r_ptr;
    assign full    = w_full;
    assign empty   = w_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomised scoreboard bench for stack_arbiter: a queue-based stack model
// predicts each transaction, a monitor compares on every gnt/done pulse.
module tb_stack_arbiter;

    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          req_a, req_b, rw_a, rw_b;
    logic [DW-1:0] datain_a, datain_b, dataout;
    logic          gnt_a, gnt_b, done_a, done_b, err, full, empty;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit at_resp = 1'b0;

    typedef struct {
        bit win_b;
        bit err;
        int dout;
        int count;
        int gnt_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   m_stack[$];
    bit   m_prio_b = 1'b0;
    int   m_dout = 0;

    stack_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .rw_a     (rw_a),
        .rw_b     (rw_b),
        .datain_a (datain_a),
        .datain_b (datain_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .done_a   (done_a),
        .done_b   (done_b),
        .dataout  (dataout),
        .err      (err),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event/timeout expected none (cycle %0d)", name, cyc);
    endtask

    // Issue one request set and predict its outcome at transaction level
    task automatic start_txn(input bit ra, input bit rb, input bit wa, input bit wb,
                             input int da, input int db);
        exp_t e;
        bit   b_wins;
        bit   op;
        int   d;
        req_a = ra; req_b = rb; rw_a = wa; rw_b = wb;
        datain_a = DW'(da); datain_b = DW'(db);
        b_wins   = rb && (!ra || m_prio_b);
        m_prio_b = !b_wins;
        op = b_wins ? wb : wa;
        d  = (b_wins ? db : da) & ((1 << DW) - 1);
        e.err = 1'b0;
        if (op) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(d);
            else e.err = 1'b1;
        end else begin
            if (m_stack.size() > 0) m_dout = m_stack.pop_back();
            else begin
                m_dout = 0;
                e.err  = 1'b1;
            end
        end
        e.win_b   = b_wins;
        e.dout    = m_dout;
        e.count   = m_stack.size();
        e.gnt_cyc = cyc + (at_resp ? 2 : 1);
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (done_a || done_b) seen = 1'b1;
        end
        if (!seen) fail_msg("done_timeout");
        at_resp = seen;
    endtask

    task automatic run(input bit ra, input bit rb, input bit wa, input bit wb,
                       input int da, input int db);
        start_txn(ra, rb, wa, wb, da, db);
        wait_done();
    endtask

    task automatic idle(input int n);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (n) @(negedge clk);
        at_resp = 1'b0;
    endtask

    task automatic do_reset();
        req_a = 1'b0;
        req_b = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_err", err, 0);
        chk("rst_dataout", dataout, 0);
        m_stack.delete();
        m_prio_b = 1'b0;
        m_dout   = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        at_resp = 1'b0;
    endtask

    // Scoreboard monitor: compares every grant and completion pulse
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (gnt_a || gnt_b) begin
            if (exp_q.size() == 0) fail_msg("unexpected_gnt");
            else begin
                chk("gnt_b", gnt_b, exp_q[0].win_b);
                chk("gnt_a", gnt_a, !exp_q[0].win_b);
                chk("gnt_cycle", cyc, exp_q[0].gnt_cyc);
            end
        end
        if (done_a || done_b) begin
            if (exp_q.size() == 0) fail_msg("unexpected_done");
            else begin
                e = exp_q.pop_front();
                chk("done_b", done_b, e.win_b);
                chk("done_a", done_a, !e.win_b);
                chk("done_cycle", cyc, e.gnt_cyc + 1);
                chk("err", err, e.err);
                chk("dataout", dataout, e.dout);
                chk("count", count, e.count);
                chk("full", full, (e.count == DEPTH) ? 1 : 0);
                chk("empty", empty, (e.count == 0) ? 1 : 0);
            end
        end else begin
            chk("err_outside_resp", err, 0);
        end
    end

    initial begin
        int n;
        bit ra, rb;
        rst = 1'b0;
        req_a = 1'b0; req_b = 1'b0; rw_a = 1'b0; rw_b = 1'b0;
        datain_a = '0; datain_b = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // A pushes 3, 7, 9 holding req across done
        run(1, 0, 1, 0, 3, 0);
        run(1, 0, 1, 0, 7, 0);
        run(1, 0, 1, 0, 9, 0);
        idle(2);

        // B pops 9, 7, 3 then underflows
        repeat (4) run(0, 1, 0, 0, 0, 0);
        idle(1);

        // Both requesting continuously: grants must alternate
        for (int i = 0; i < 8; i++)
            run(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        idle(1);

        // Fill to DEPTH, overflow once, pop the top
        do_reset();
        for (int i = 0; i < DEPTH; i++) run(1, 0, 1, 0, i, 0);
        run(1, 0, 1, 0, 5, 0);
        run(1, 0, 0, 0, 0, 0);
        idle(2);

        // Random mix of requesters, operations and idle gaps
        for (int i = 0; i < 60; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            run(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        // Reset asserted in the EXEC cycle abandons the transaction
        start_txn(1, 0, 1, 0, 6, 0);
        n = 0;
        while (!(gnt_a || gnt_b) && n < 5) begin
            @(negedge clk);
            n++;
        end
        if (!(gnt_a || gnt_b)) fail_msg("gnt_timeout");
        do_reset();

        run(0, 1, 1, 1, 0, 11);
        run(1, 1, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
